// File: rtl/muldiv_unit_pkg.sv
// rtl/muldiv_unit_pkg.sv - shared operation codes, states and latency for the RV32M iterative unit
package muldiv_unit_pkg;

    localparam int MD_XLEN    = 32;
    // start in cycle 0, XLEN CALC cycles, one FIX cycle, done in cycle XLEN+2
    localparam int MD_LATENCY = MD_XLEN + 2;

    localparam logic [4:0] ALU_MUL    = 5'd16;
    localparam logic [4:0] ALU_MULH   = 5'd17;
    localparam logic [4:0] ALU_MULHSU = 5'd18;
    localparam logic [4:0] ALU_MULHU  = 5'd19;
    localparam logic [4:0] ALU_DIV    = 5'd20;
    localparam logic [4:0] ALU_DIVU   = 5'd21;
    localparam logic [4:0] ALU_REM    = 5'd22;
    localparam logic [4:0] ALU_REMU   = 5'd23;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_CALC = 2'd1,
        MD_FIX  = 2'd2,
        MD_DONE = 2'd3
    } md_state_t;

    function automatic logic is_m_op(input logic [4:0] sel);
        return sel inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU,
                           ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative radix-2 RV32M multiply/divide unit for the EX stage
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   start, alusel       launch request and M-extension operation code (sampled when not busy)
//   op_a, op_b          rs1 / rs2 operands
//   flush               aborts any operation in flight, drops a same-cycle start
//   busy                high in CALC and FIX
//   done, result        one-cycle completion pulse and registered result
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [4:0]      alusel,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0]   CNT_LAST = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

    function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    md_state_t         state, state_nxt;
    logic [4:0]        op;
    logic              neg_res;
    logic [XLEN-1:0]   mb;
    logic [2*XLEN-1:0] acc;
    logic [CW-1:0]     cnt;

    // captured operation
    logic op_is_mul, op_mul_hi, op_is_rem;
    assign op_is_mul = op inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU};
    assign op_mul_hi = op inside {ALU_MULH, ALU_MULHSU, ALU_MULHU};
    assign op_is_rem = op inside {ALU_REM, ALU_REMU};

    // incoming request
    logic in_m, in_signed_a, in_signed_b, in_div, in_rem, sa, sb;
    logic div_zero, div_ovf, special, accept;
    logic [XLEN-1:0] spec_val;

    assign in_m        = is_m_op(alusel);
    assign in_signed_a = alusel inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_DIV, ALU_REM};
    assign in_signed_b = alusel inside {ALU_MUL, ALU_MULH, ALU_DIV, ALU_REM};
    assign in_div      = alusel inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
    assign in_rem      = alusel inside {ALU_REM, ALU_REMU};
    assign sa          = in_signed_a & op_a[XLEN-1];
    assign sb          = in_signed_b & op_b[XLEN-1];
    assign div_zero    = in_div & (op_b == '0);
    assign div_ovf     = ((alusel == ALU_DIV) || (alusel == ALU_REM))
                         & (op_a == MIN_NEG) & (op_b == '1);
    assign special     = div_zero | div_ovf;
    assign accept      = start & in_m & ~flush;

    always_comb begin
        spec_val = '0;
        if (div_zero)
            spec_val = in_rem ? op_a : '1;
        else
            spec_val = in_rem ? '0 : MIN_NEG;
    end

    // Shared adder. Two guard bits: bit XLEN is the multiply carry, bit XLEN+1
    // is the borrow of the trial subtraction (operands never exceed XLEN+1 bits).
    logic [XLEN+1:0] add_x, add_y, add_sum;
    logic            add_cin;
    logic [XLEN-1:0] fix_sel;

    assign fix_sel = (op_mul_hi | op_is_rem) ? acc[2*XLEN-1:XLEN] : acc[XLEN-1:0];

    always_comb begin
        add_x   = '0;
        add_y   = '0;
        add_cin = 1'b0;
        if (state == MD_CALC) begin
            if (op_is_mul) begin
                add_x = {2'b00, acc[2*XLEN-1:XLEN]};
                add_y = acc[0] ? {2'b00, mb} : '0;
            end else begin
                add_x   = {1'b0, acc[2*XLEN-1:XLEN-1]};
                add_y   = ~{2'b00, mb};
                add_cin = 1'b1;
            end
        end else begin
            // Negation as ~v + cin. For the high product half the +1 only
            // propagates out of the low half when the low half is all zero.
            add_x   = {2'b00, neg_res ? ~fix_sel : fix_sel};
            add_cin = neg_res & (op_mul_hi ? (acc[XLEN-1:0] == '0) : 1'b1);
        end
    end

    assign add_sum = add_x + add_y + {{(XLEN+1){1'b0}}, add_cin};

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= MD_IDLE;
        else
            state <= state_nxt;
    end

    // next state and outputs
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            MD_IDLE: begin
                if (start && in_m)
                    state_nxt = special ? MD_DONE : MD_CALC;
            end
            MD_CALC: begin
                busy = 1'b1;
                if (cnt == CNT_LAST)
                    state_nxt = MD_FIX;
            end
            MD_FIX: begin
                busy      = 1'b1;
                state_nxt = MD_DONE;
            end
            MD_DONE: begin
                done = 1'b1;
                if (start && in_m)
                    state_nxt = special ? MD_DONE : MD_CALC;
                else
                    state_nxt = MD_IDLE;
            end
            default: state_nxt = MD_IDLE;
        endcase
        if (flush)
            state_nxt = MD_IDLE;
    end

    // datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op      <= '0;
            neg_res <= 1'b0;
            mb      <= '0;
            acc     <= '0;
            cnt     <= '0;
            result  <= '0;
        end else begin
            case (state)
                MD_IDLE, MD_DONE: begin
                    if (accept) begin
                        op      <= alusel;
                        cnt     <= '0;
                        mb      <= abs_val(op_b, sb);
                        acc     <= {{XLEN{1'b0}}, abs_val(op_a, sa)};
                        neg_res <= in_rem ? sa : (sa ^ sb);
                        if (special)
                            result <= spec_val;
                    end
                end
                MD_CALC: begin
                    if (!flush) begin
                        cnt <= (cnt == CNT_LAST) ? '0 : cnt + CW'(1);
                        if (op_is_mul)
                            acc <= {add_sum[XLEN:0], acc[XLEN-1:1]};
                        else if (!add_sum[XLEN+1])
                            acc <= {add_sum[XLEN-1:0], acc[XLEN-2:0], 1'b1};
                        else
                            acc <= {acc[2*XLEN-2:0], 1'b0};
                    end
                end
                MD_FIX: begin
                    if (!flush)
                        result <= add_sum[XLEN-1:0];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - self-checking bench for muldiv_unit
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

    localparam int XLEN = 32;
    localparam logic [31:0] MINV = 32'h8000_0000;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic            flush = 1'b0;
    logic [4:0]      alusel = '0;
    logic [XLEN-1:0] op_a = '0;
    logic [XLEN-1:0] op_b = '0;
    logic            busy, done;
    logic [XLEN-1:0] result;

    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] last_exp = '0;

    muldiv_unit #(.XLEN(XLEN)) dut (
        .clk(clk), .rst(rst), .start(start), .alusel(alusel),
        .op_a(op_a), .op_b(op_b), .flush(flush),
        .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // reference: plain 64-bit arithmetic on sign/zero-extended operands
    function automatic logic [31:0] ref_op(input logic [4:0] sel, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] as64, bs64, au64, bu64, p;
        as64 = {{32{a[31]}}, a};
        bs64 = {{32{b[31]}}, b};
        au64 = {32'b0, a};
        bu64 = {32'b0, b};
        case (sel)
            ALU_MUL:    begin p = as64 * bs64; return p[31:0];  end
            ALU_MULH:   begin p = as64 * bs64; return p[63:32]; end
            ALU_MULHSU: begin p = as64 * bu64; return p[63:32]; end
            ALU_MULHU:  begin p = au64 * bu64; return p[63:32]; end
            ALU_DIV: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == MINV && b == 32'hFFFF_FFFF) return MINV;
                p = as64 / bs64; return p[31:0];
            end
            ALU_REM: begin
                if (b == 0) return a;
                if (a == MINV && b == 32'hFFFF_FFFF) return 32'h0;
                p = as64 % bs64; return p[31:0];
            end
            ALU_DIVU: begin
                if (b == 0) return 32'hFFFF_FFFF;
                p = au64 / bu64; return p[31:0];
            end
            ALU_REMU: begin
                if (b == 0) return a;
                p = au64 % bu64; return p[31:0];
            end
            default: return 32'h0;
        endcase
    endfunction

    function automatic bit is_special(input logic [4:0] sel, input logic [31:0] a, input logic [31:0] b);
        if (sel inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU} && b == 0) return 1'b1;
        if (sel inside {ALU_DIV, ALU_REM} && a == MINV && b == 32'hFFFF_FFFF) return 1'b1;
        return 1'b0;
    endfunction

    // caller is at a negedge; start is held for exactly one rising edge
    task automatic launch(input logic [4:0] sel, input logic [31:0] a, input logic [31:0] b);
        alusel = sel;
        op_a   = a;
        op_b   = b;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        alusel = 5'($urandom);
        op_a   = $urandom;
        op_b   = $urandom;
    endtask

    // lat counts cycles after the start cycle; 0 means no done within the budget
    task automatic wait_done(output int lat, output logic [31:0] got, output int busy_n);
        lat    = 0;
        got    = 'x;
        busy_n = 0;
        for (int c = 1; c <= 60 && lat == 0; c++) begin
            @(negedge clk);
            if (busy) busy_n++;
            if (done) begin
                lat = c;
                got = result;
            end
        end
    endtask

    task automatic count_dones(input int ncyc, output int n);
        n = 0;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            if (done) n++;
        end
    endtask

    task automatic do_op(input logic [4:0] sel, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input string tag);
        int lat, busy_n;
        logic [31:0] got;
        bit sp;
        sp = is_special(sel, a, b);
        @(negedge clk);
        launch(sel, a, b);
        wait_done(lat, got, busy_n);
        check({tag, " result"}, got, exp);
        check({tag, " latency"}, 32'(lat), sp ? 32'd1 : 32'(MD_LATENCY));
        check({tag, " busy cycles"}, 32'(busy_n), sp ? 32'd0 : 32'(MD_LATENCY - 1));
        last_exp = exp;
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return MINV;
            4: return 32'h7FFF_FFFF;
            5: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    typedef struct {
        logic [4:0]  sel;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        string       tag;
    } vec_t;

    vec_t dir[12];

    logic [4:0] ops[8];

    initial begin
        int lat, busy_n, n;
        logic [31:0] got, a, b;
        logic [4:0] sel;

        ops = '{ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
        dir[0]  = '{ALU_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, "mul 7*-3"};
        dir[1]  = '{ALU_MULH,   MINV,           MINV,          32'h4000_0000, "mulh min*min"};
        dir[2]  = '{ALU_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu max"};
        dir[3]  = '{ALU_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu -1*max"};
        dir[4]  = '{ALU_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, "div -7/2"};
        dir[5]  = '{ALU_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, "rem -7%2"};
        dir[6]  = '{ALU_DIVU,   32'd100,        32'd7,         32'd14,        "divu 100/7"};
        dir[7]  = '{ALU_REMU,   32'd100,        32'd7,         32'd2,         "remu 100%7"};
        dir[8]  = '{ALU_DIVU,   32'd5,          32'd0,         32'hFFFF_FFFF, "divu by 0"};
        dir[9]  = '{ALU_REM,    32'd5,          32'd0,         32'd5,         "rem by 0"};
        dir[10] = '{ALU_DIV,    MINV,           32'hFFFF_FFFF, MINV,          "div overflow"};
        dir[11] = '{ALU_REM,    MINV,           32'hFFFF_FFFF, 32'd0,         "rem overflow"};

        // reset state
        #12;
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset result", result, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // non-M code is ignored
        @(negedge clk);
        launch(5'd0, 32'd3, 32'd4);
        count_dones(5, n);
        check("non-M ignored dones", 32'(n), 32'd0);
        check("non-M ignored busy", 32'(busy), 32'd0);

        // directed vectors
        foreach (dir[i])
            do_op(dir[i].sel, dir[i].a, dir[i].b, dir[i].exp, dir[i].tag);

        // back-to-back: second start presented in the DONE cycle
        @(negedge clk);
        launch(ALU_MULHU, 32'h1234_5678, 32'h9ABC_DEF0);
        wait_done(lat, got, busy_n);
        check("b2b first result", got, ref_op(ALU_MULHU, 32'h1234_5678, 32'h9ABC_DEF0));
        launch(ALU_DIVU, 32'd100, 32'd7);
        wait_done(lat, got, busy_n);
        check("b2b second result", got, 32'd14);
        check("b2b second latency", 32'(lat), 32'(MD_LATENCY));

        // start while busy is dropped
        @(negedge clk);
        launch(ALU_MUL, 32'h1234, 32'h10);
        repeat (4) @(negedge clk);
        alusel = ALU_DIVU; op_a = 32'd99; op_b = 32'd9; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(lat, got, busy_n);
        check("busy-start result", got, 32'h12340);
        count_dones(40, n);
        check("busy-start extra done", 32'(n), 32'd0);
        last_exp = 32'h12340;

        // flush in cycle 10 of a DIV
        @(negedge clk);
        launch(ALU_DIV, 32'd1000, 32'd3);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        check("flush busy", 32'(busy), 32'd0);
        count_dones(40, n);
        check("flush no done", 32'(n), 32'd0);
        check("flush result held", result, last_exp);
        do_op(ALU_MUL, 32'd3, 32'd4, 32'd12, "mul after flush");

        // flush together with start in IDLE
        @(negedge clk);
        flush = 1'b1;
        launch(ALU_MUL, 32'd5, 32'd5);
        flush = 1'b0;
        count_dones(40, n);
        check("flush+start no done", 32'(n), 32'd0);
        check("flush+start result", result, 32'd12);

        // asynchronous reset mid-CALC
        @(negedge clk);
        launch(ALU_MUL, 32'd9, 32'd9);
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async rst busy", 32'(busy), 32'd0);
        check("async rst done", 32'(done), 32'd0);
        check("async rst result", result, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        count_dones(40, n);
        check("after rst no done", 32'(n), 32'd0);

        // randomized operations against the reference
        for (int i = 0; i < 80; i++) begin
            sel = ops[$urandom_range(0, 7)];
            a   = pick_operand();
            b   = pick_operand();
            do_op(sel, a, b, ref_op(sel, a, b), $sformatf("rand%0d op%0d", i, sel));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M execution unit for the EX stage: the consumer of the M-extension `alusel` codes produced by the ALU control decode. It accepts one MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU operation per `start` and computes it over multiple cycles using radix-2 shift-add or shift-subtract. It drives `busy` to the hazard/stall logic and pulses `done` with the 32-bit result for EX/MEM writeback.

## Interface
- `XLEN`, default 32: operand/result width. The iteration counter is `$clog2(XLEN)` bits wide.
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous reset, active-high
- `start`  in  1  launch request; sampled only when `busy`=0
- `alusel`  in  5  operation select; uses the `ALU_MUL` … `ALU_REMU` macros from `include/defines.v`
- `op_a`  in  XLEN  rs1 operand (multiplicand / dividend)
- `op_b`  in  XLEN  rs2 operand (multiplier / divisor)
- `flush`  in  1  pipeline kill; aborts the operation in flight
- `busy`  out  1  high while an operation is in flight
- `done`  out  1  one-cycle pulse; `result` is valid in this cycle
- `result`  out  XLEN  registered result; holds its value until the next `done`

## Operation
- States are IDLE, CALC, FIX and DONE. `busy`=1 in CALC and FIX only. `done`=1 in DONE only.
- **IDLE:**
  - `start`=1 with a non-M `alusel` is ignored.
  - `start`=1 with an M code captures `alusel`, the operand magnitudes, and the sign flags. Inputs may change afterwards.
- **Signedness:**
  - MUL, MULH, DIV, REM treat both operands as signed.
  - MULHSU treats `op_a` as signed and `op_b` as unsigned.
  - MULHU, DIVU, REMU treat both operands as unsigned.
- **Result signs:** product and quotient sign = sa XOR sb. Remainder sign = dividend sign.
- **Special cases:** these are detected in IDLE and go IDLE→DONE directly, with no CALC.
  - Divide by zero: DIV/DIVU return all ones; REM/REMU return the dividend.
  - Signed overflow (DIV of 0x80000000 by −1): DIV returns 0x80000000, REM returns 0.
- **CALC:** runs exactly XLEN cycles, one bit per cycle.
  - Multiply: 2·XLEN product register, shift-add.
  - Divide: restoring division on a 2·XLEN remainder:quotient register.
  - The counter ends at XLEN−1, then the state moves to FIX.
- **FIX:**
  - Applies two's-complement negation per the sign flags.
  - Selects the output half: MUL takes the low half, MULH* take the high half, DIV* take the quotient, REM* take the remainder.
  - Registers `result`. Next state is DONE.
- **DONE:** lasts one cycle, then IDLE. `busy`=0, so a `start` presented in DONE is accepted as from IDLE.
- **`start` while `busy`=1:** ignored. No queuing.
- **`flush`:** in any state, the next state is IDLE. No `done` is produced and `result` is unchanged. `flush` together with `start` in IDLE means the start is dropped.
- **Reset:** `busy`=0, `done`=0, `result`=0, state = IDLE, counter = 0. Reset mid-operation discards the operation.

## Timing
- Normal op, `start` in cycle 0: CALC in cycles 1..XLEN, FIX in cycle XLEN+1, `done` in cycle XLEN+2 (34 for XLEN=32).
- Special case, `start` in cycle 0: `done` in cycle 1, `busy` never asserted.
- Back-to-back: `start` in the DONE cycle gives the next `done` XLEN+2 cycles later. Peak throughput is one op per XLEN+2 cycles.
- `busy` rises in the cycle after `start` is accepted. The stall logic must OR `start` with `busy` for the issue cycle.

## Structure
- Add to `include/defines.v`:
  - the state encodings `MD_IDLE`, `MD_CALC`, `MD_FIX`, `MD_DONE`
  - the constant `MD_LATENCY` (= XLEN+2)
- The `ALU_*` and `F3_*` codes already live there and are reused unchanged.
- Single module, no sub-module. The negate/abs helpers are local functions; one shared adder/subtractor serves both the CALC and FIX paths.

## Test plan
- MUL 7 × 0xFFFFFFFD → `result`=0xFFFFFFEB, `done` in cycle 34, `busy` high in cycles 1–33.
- MULH 0x80000000 × 0x80000000 → 0x40000000. MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD. REM same operands → 0xFFFFFFFF. DIVU 100 / 7 → 14. REMU → 2.
- DIVU 5 / 0 → 0xFFFFFFFF with `done` in cycle 1. REM 5 % 0 → 5. DIV 0x80000000 / 0xFFFFFFFF → 0x80000000. REM same operands → 0.
- `flush` in cycle 10 of a DIV → IDLE next cycle, no `done`, `result` unchanged. A new MUL 3 × 4 started afterwards → 12.
- `rst` asserted asynchronously mid-CALC → outputs 0 immediately. A `start` ignored while `busy`=1 never produces a second `done`.
